raw_hazard_scoreboard: RTL and testbench
========================================

Name: raw_hazard_scoreboard

Overview:
Parametrised successor to the single-writeback ID RAW stall detector. It tracks the number of in-flight writes to every architectural register using per-register pending counters, rather than comparing against one writeback stage. It stalls Decode while any used source register has an outstanding write, with an optional same-cycle writeback bypass. It sits between Decode (issue side) and Writeback (retire side) of the multicycle pipeline, and exports a stall-cycle performance counter.

Parameters:
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (must equal 2**ADDR_W).
- NUM_SRC, 2, number of source operands checked per issuing instruction.
- PEND_W, 2, pending-counter width; max outstanding writes per register = 2**PEND_W-1.
- WB_BYPASS, 1, 1 = a writeback retiring the last pending write this cycle does not cause a stall.
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- issue_valid  in  1  Decode presents an instruction
- issue_regwrite  in  1  instruction writes rd
- issue_rd  in  ADDR_W  destination register
- rs_addr  in  NUM_SRC x ADDR_W  source register addresses
- rs_used  in  NUM_SRC  per-source "operand actually read" flag
- wb_valid  in  1  Writeback retires a register write this cycle
- wb_rd  in  ADDR_W  retiring destination
- flush  in  1  pipeline flush; discard all pending state
- stall  out  1  hold Decode this cycle
- issue_accept  out  1  issue_valid & ~stall
- hazard_mask  out  NUM_SRC  per-source hazard flag, for debug
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1
- underflow_err  out  1  sticky: writeback to a register with zero pending

Behaviour:
- Reset and clocking:
  - One clock domain, clk. Reset is synchronous and active-high (rst).
  - On rst: all pend[r]=0, stall_cycles=0, underflow_err=0.
  - While rst=1: stall=0, hazard_mask=0, issue_accept=0.
- Register x0: never tracked. Issues and writebacks to x0 do not change any counter. A source of x0 never hazards.
- Source hazard, combinational from the current state:
  - hz[i] = rs_used[i] & (rs_addr[i]!=0) & (pend[rs_addr[i]]!=0).
  - If WB_BYPASS=1, hz[i] is additionally cleared when wb_valid & wb_rd==rs_addr[i] & pend[rs_addr[i]]==1.
  - hazard_mask = hz when issue_valid=1, else 0.
- Structural stall: stall also asserts when issue_valid & issue_regwrite & issue_rd!=0 & pend[issue_rd]==MAX and no wb to issue_rd this cycle (counter full).
- Stall: stall = issue_valid & ~rst & (|hz | full_stall).
- Counter update (next-cycle):
  - inc = issue_accept & issue_regwrite & issue_rd==r.
  - dec = wb_valid & wb_rd==r & pend[r]!=0.
  - inc&dec: unchanged. inc only: +1. dec only: -1.
  - Never wraps in either direction.
- Underflow: wb_valid & wb_rd!=0 & pend[wb_rd]==0 sets underflow_err (sticky until rst). The counter stays at 0.
- Flush: on flush=1 (and rst=0), all pend cleared next cycle, and the same-cycle inc/dec is ignored. stall is still computed from the pre-flush state in that cycle. stall_cycles and underflow_err are not cleared by flush.
- Counter: stall_cycles increments every cycle stall=1 and saturates at all-ones.
- Latency:
  - A write issued in cycle N is visible as a hazard from cycle N+1.
  - A writeback in cycle N clears it for cycle N (bypass) or N+1 (no bypass).

Decomposition:
- hazard_pkg: ADDR_W/NUM_REGS defaults, the reg_addr_t typedef, and the REG_ZERO constant.
- Sub-module reg_pend_counter (inputs inc, dec, clr; outputs cnt, is_zero, is_max, underflow), instantiated per register r=1..NUM_REGS-1 via generate.

Test Plan:
- Basic RAW: issue rd=5 (regwrite) in cycle 0, then in cycle 1 issue rs1=5 used -> stall=1, hazard_mask=2'b01. Apply wb_rd=5 in cycle 3 -> with WB_BYPASS=1, stall=0 in cycle 3 and issue_accept=1.
- x0 and unused operands: rs1=0, rs2=7 with rs_used=2'b01 while pend[7]=1 -> stall=0. Issue rd=0 -> no counter change, so a later rs1=0 never stalls.
- Multiple in-flight writes: two issues to rd=9, then one wb to 9 -> pend[9]=1 and rs1=9 still stalls. Second wb -> stall clears.
- Saturation: PEND_W=2, three writes to rd=4 pending -> a fourth issue to rd=4 has stall=1 with hazard_mask=0. Adding a wb to 4 in the same cycle -> accepted, pend[4] stays 3.
- Flush and reset mid-operation: pend[3]=2 and pend[8]=1, assert flush -> next cycle rs1=3, rs2=8 gives no stall, while stall_cycles is retained. Assert rst during a stall -> stall=0 immediately and stall_cycles=0 next cycle.
- Underflow and perf counter: wb_rd=12 with pend[12]=0 -> underflow_err=1 held until rst. Ten stall cycles -> stall_cycles=10. With CNT_W=4, 20 stall cycles -> 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared defaults, register address type and the hardwired-zero register constant.
package hazard_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_REGS = 2 ** DEF_ADDR_W;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/reg_pend_counter.sv
// reg_pend_counter: per-register count of in-flight writes (inc on issue, dec on retire, clr on flush); never wraps.
module reg_pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [PEND_W-1:0] cnt,
  output logic              is_zero,
  output logic              is_max,
  output logic              underflow
);
  logic dec_ok;
  assign is_zero = cnt == '0;
  assign is_max = &cnt;
  assign dec_ok = dec & ~is_zero;
  assign underflow = dec & is_zero;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && !dec_ok && !is_max) cnt <= cnt + 1'b1;
    else if (dec_ok && !inc) cnt <= cnt - 1'b1;
endmodule

// File: rtl/raw_hazard_scoreboard.sv
// raw_hazard_scoreboard: stalls Decode while a used source has an outstanding write, tracked by per-register pending counters.
module raw_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_SRC = 2,
  parameter int PEND_W = 2,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_valid,
  input  logic                           issue_regwrite,
  input  logic [ADDR_W-1:0]              issue_rd,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0] rs_addr,
  input  logic [NUM_SRC-1:0]             rs_used,
  input  logic                           wb_valid,
  input  logic [ADDR_W-1:0]              wb_rd,
  input  logic                           flush,
  output logic                           stall,
  output logic                           issue_accept,
  output logic [NUM_SRC-1:0]             hazard_mask,
  output logic [CNT_W-1:0]               stall_cycles,
  output logic                           underflow_err
);
  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_ZERO);
  logic [NUM_REGS-1:0][PEND_W-1:0] pend;
  logic [NUM_REGS-1:0] is_zero, is_max, uf;
  logic [NUM_SRC-1:0] hz;
  logic live, full_stall;
  assign pend[0] = '0;
  assign is_zero[0] = 1'b1;
  assign is_max[0] = 1'b0;
  assign uf[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    reg_pend_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (issue_accept & issue_regwrite & (issue_rd == ADDR_W'(r))),
      .dec      (wb_valid & (wb_rd == ADDR_W'(r))),
      .clr      (flush),
      .cnt      (pend[r]),
      .is_zero  (is_zero[r]),
      .is_max   (is_max[r]),
      .underflow(uf[r])
    );
  end
  // A retire of the last pending write this cycle forwards the value, so it does not hazard.
  always_comb begin
    hz = '0;
    for (int i = 0; i < NUM_SRC; i++)
      hz[i] = rs_used[i] & (rs_addr[i] != X0) & ~is_zero[rs_addr[i]]
            & ~((WB_BYPASS != 0) & wb_valid & (wb_rd == rs_addr[i]) & (pend[rs_addr[i]] == PEND_W'(1)));
  end
  // A full counter can still take a new write when a retire to the same register frees a slot.
  assign full_stall = issue_regwrite & (issue_rd != X0) & is_max[issue_rd] & ~(wb_valid & (wb_rd == issue_rd));
  assign live = issue_valid & ~rst;
  assign stall = live & ((|hz) | full_stall);
  assign issue_accept = live & ~stall;
  assign hazard_mask = live ? hz : '0;
  always_ff @(posedge clk) begin
    stall_cycles <= rst ? '0 : (stall && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
    underflow_err <= rst ? 1'b0 : underflow_err | (|uf);
  end
endmodule

// File: tb/tb_raw_hazard_scoreboard.sv
// tb_raw_hazard_scoreboard: directed and random stimulus checked every cycle against a behavioural scoreboard model.
module tb_raw_hazard_scoreboard;
  localparam int CW = 5;
  localparam int SMAX = 2 ** CW - 1;
  localparam int PMAX = 3;
  logic clk = 0;
  logic rst, iv, rw, wbv, flush;
  logic [4:0] rd, wbrd;
  logic [1:0][4:0] rs;
  logic [1:0] used;
  logic stall, acc, uerr;
  logic [1:0] hm;
  logic [CW-1:0] sc;
  int pass_n = 0, total_n = 0;
  int pend_m[32];
  int sc_m = 0;
  bit uf_m = 0;
  bit live = 0;
  raw_hazard_scoreboard #(.ADDR_W(5), .NUM_REGS(32), .NUM_SRC(2), .PEND_W(2), .WB_BYPASS(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .issue_valid(iv), .issue_regwrite(rw), .issue_rd(rd),
    .rs_addr(rs), .rs_used(used), .wb_valid(wbv), .wb_rd(wbrd), .flush(flush),
    .stall(stall), .issue_accept(acc), .hazard_mask(hm), .stall_cycles(sc), .underflow_err(uerr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    total_n++;
    if (got == exp) pass_n++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
  endtask
  function automatic void model_out(output bit st, output bit ac, output bit [1:0] hme);
    bit full;
    hme = 0;
    for (int i = 0; i < 2; i++) begin
      int a = int'(rs[i]);
      if (used[i] && a != 0 && pend_m[a] > 0 && !(wbv && int'(wbrd) == a && pend_m[a] == 1)) hme[i] = 1;
    end
    full = rw && rd != 0 && pend_m[rd] == PMAX && !(wbv && wbrd == rd);
    st = !rst && iv && (hme != 0 || full);
    ac = !rst && iv && !st;
    if (rst || !iv) hme = 0;
  endfunction
  always @(posedge clk) begin
    bit st, ac;
    bit [1:0] hme;
    model_out(st, ac, hme);
    if (rst) begin
      foreach (pend_m[k]) pend_m[k] = 0;
      sc_m = 0;
      uf_m = 0;
    end else begin
      if (st && sc_m < SMAX) sc_m++;
      if (wbv && wbrd != 0 && pend_m[wbrd] == 0) uf_m = 1;
      if (flush) foreach (pend_m[k]) pend_m[k] = 0;
      else begin
        if (wbv && wbrd != 0 && pend_m[wbrd] > 0) pend_m[wbrd]--;
        if (ac && rw && rd != 0) pend_m[rd]++;
      end
    end
    live = 1;
  end
  always @(negedge clk) if (live) begin
    bit st, ac;
    bit [1:0] hme;
    model_out(st, ac, hme);
    chk("m_stall", int'(stall), int'(st));
    chk("m_accept", int'(acc), int'(ac));
    chk("m_hmask", int'(hm), int'(hme));
    chk("m_stall_cycles", int'(sc), sc_m);
    chk("m_underflow", int'(uerr), int'(uf_m));
  end
  task automatic idle();
    iv = 0; rw = 0; rd = 0; rs = '0; used = 0; wbv = 0; wbrd = 0; flush = 0;
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    foreach (pend_m[k]) pend_m[k] = 0;
    rst = 1;
    idle();
    iv = 1; rw = 1; rd = 5; rs[0] = 5; used = 1;
    @(posedge clk);
    #1;
    #3 chk("rst_accept", int'(acc), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_sc", int'(sc), 0);
    nxt();
    rst = 0;
    iv = 1; rw = 1; rd = 5;
    #3 chk("raw_issue_acc", int'(acc), 1);
    nxt();
    iv = 1; rs[0] = 5; used = 1;
    #3 chk("raw_stall", int'(stall), 1);
    chk("raw_hmask", int'(hm), 1);
    nxt();
    iv = 1; rs[0] = 5; used = 1;
    nxt();
    iv = 1; rs[0] = 5; used = 1; wbv = 1; wbrd = 5;
    #3 chk("raw_bypass_stall", int'(stall), 0);
    chk("raw_bypass_acc", int'(acc), 1);
    nxt();
    iv = 1; rw = 1; rd = 7;
    nxt();
    iv = 1; rs[0] = 0; rs[1] = 7; used = 2'b01;
    #3 chk("x0_unused", int'(stall), 0);
    nxt();
    iv = 1; rw = 1; rd = 0;
    nxt();
    iv = 1; used = 2'b11;
    #3 chk("x0_src", int'(stall), 0);
    nxt();
    wbv = 1; wbrd = 7;
    nxt();
    iv = 1; rw = 1; rd = 9;
    nxt();
    iv = 1; rw = 1; rd = 9;
    nxt();
    wbv = 1; wbrd = 9;
    nxt();
    iv = 1; rs[0] = 9; used = 1;
    #3 chk("multi_still", int'(stall), 1);
    nxt();
    iv = 1; rs[0] = 9; used = 1; wbv = 1; wbrd = 9;
    #3 chk("multi_clear", int'(stall), 0);
    nxt();
    repeat (3) begin
      iv = 1; rw = 1; rd = 4;
      nxt();
    end
    iv = 1; rw = 1; rd = 4;
    #3 chk("sat_stall", int'(stall), 1);
    chk("sat_hmask", int'(hm), 0);
    nxt();
    iv = 1; rw = 1; rd = 4; wbv = 1; wbrd = 4;
    #3 chk("sat_wb_acc", int'(acc), 1);
    nxt();
    wbv = 1; wbrd = 4;
    nxt();
    wbv = 1; wbrd = 4;
    nxt();
    iv = 1; rs[0] = 4; used = 1;
    #3 chk("sat_pend_one_stall", int'(stall), 1);
    nxt();
    wbv = 1; wbrd = 4;
    nxt();
    #3 chk("sat_no_underflow", int'(uerr), 0);
    iv = 1; rw = 1; rd = 3;
    nxt();
    iv = 1; rw = 1; rd = 3;
    nxt();
    iv = 1; rw = 1; rd = 8;
    nxt();
    #3 chk("pre_flush_sc", int'(sc), 5);
    flush = 1; iv = 1; rs[0] = 3; used = 1;
    #3 chk("flush_cycle_stall", int'(stall), 1);
    nxt();
    iv = 1; rs[0] = 3; rs[1] = 8; used = 2'b11;
    #3 chk("post_flush_stall", int'(stall), 0);
    chk("post_flush_sc", int'(sc), 6);
    nxt();
    iv = 1; rw = 1; rd = 3;
    nxt();
    iv = 1; rs[0] = 3; used = 1; rst = 1;
    #3 chk("rst_kills_stall", int'(stall), 0);
    nxt();
    rst = 0;
    #3 chk("rst_sc_clear", int'(sc), 0);
    wbv = 1; wbrd = 12;
    #1 chk("uf_before", int'(uerr), 0);
    nxt();
    #3 chk("uf_set", int'(uerr), 1);
    flush = 1;
    nxt();
    repeat (3) nxt();
    #3 chk("uf_sticky", int'(uerr), 1);
    rst = 1;
    nxt();
    rst = 0;
    #3 chk("uf_rst", int'(uerr), 0);
    iv = 1; rw = 1; rd = 6;
    nxt();
    repeat (10) begin
      iv = 1; rs[0] = 6; used = 1;
      nxt();
    end
    #3 chk("sc_ten", int'(sc), 10);
    repeat (30) begin
      iv = 1; rs[0] = 6; used = 1;
      nxt();
    end
    #3 chk("sc_sat", int'(sc), SMAX);
    wbv = 1; wbrd = 6;
    nxt();
    repeat (3000) begin
      iv = $urandom_range(0, 3) != 0;
      rw = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 7));
      rs[0] = 5'($urandom_range(0, 7));
      rs[1] = 5'($urandom_range(0, 7));
      used = 2'($urandom_range(0, 3));
      wbv = $urandom_range(0, 2) == 0;
      wbrd = 5'($urandom_range(0, 7));
      flush = $urandom_range(0, 99) == 0;
      rst = $urandom_range(0, 299) == 0;
      @(posedge clk);
      #1;
    end
    rst = 0;
    idle();
    repeat (2) nxt();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
